// File: rtl/csa_mpadd_seq.sv
// rtl/csa_mpadd_seq.sv - multi-precision add/subtract sequencer over one 16-bit carry-select slice

module csa_mpadd_slice (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] c;

    assign c[0] = cin;

    // Each 4-bit block precomputes both carry-in outcomes; the incoming carry only drives the mux.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign r1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
        assign {c[g+1], sum[4*g +: 4]} = c[g] ? r1 : r0;
    end

    assign cout = c[4];
endmodule

module csa_mpadd_seq #(
    parameter  int WORDS = 4,
    localparam int CNT_W = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] in_a,
    input  logic [16*WORDS-1:0] in_b,
    input  logic                in_sub,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                busy
);
    localparam int               W        = 16 * WORDS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      res_q, res_d;
    logic [W-1:0]      out_sum_q, out_sum_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [15:0]       slice_a;
    logic [15:0]       slice_b;
    logic [15:0]       slice_sum;
    logic              slice_cout;

    assign slice_a = a_q[16*idx_q +: 16];
    assign slice_b = b_q[16*idx_q +: 16];

    csa_mpadd_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtract is folded into the add path: A + ~B + 1.
                    a_d        = in_a;
                    b_d        = in_sub ? ~in_b : in_b;
                    carry_d    = in_sub ? 1'b1 : in_cin;
                    idx_d      = '0;
                    res_d      = '0;
                    out_sum_d  = '0;
                    out_cout_d = 1'b0;
                    out_ovf_d  = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == CNT_W'(i)) begin
                        res_d[16*i +: 16] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    out_sum_d   = res_d;
                    out_cout_d  = slice_cout;
                    out_ovf_d   = (slice_a[15] == slice_b[15]) && (slice_sum[15] != slice_a[15]);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_csa_mpadd_seq.sv
// tb/tb_csa_mpadd_seq.sv - scoreboard bench for csa_mpadd_seq against a wide-arithmetic model

module tb_csa_mpadd_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    csa_mpadd_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: exact wide arithmetic; overflow means the true signed result is out of range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t                e;
        logic [W:0]          full;
        logic signed [W+1:0] sa, sb_v, s, maxs, mins;
        sa   = $signed({a[W-1], a[W-1], a});
        sb_v = $signed({b[W-1], b[W-1], b});
        maxs = $signed({3'b000, {(W-1){1'b1}}});
        mins = $signed({3'b111, {(W-1){1'b0}}});
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
            s      = sa - sb_v;
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.cout = full[W];
            s      = sa + sb_v + $signed({{(W+1){1'b0}}, cin});
        end
        e.sum = full[W-1:0];
        e.ovf = (s > maxs) || (s < mins);
        e.acc = 0;
        return e;
    endfunction

    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out_valid", W'(1), W'(0));
                else                chk("latency", W'(cyc - sb[0].acc), W'(WORDS));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", out_sum, e.sum);
                chk("cout", W'(out_cout), W'(e.cout));
                chk("ovf", W'(out_ovf), W'(e.ovf));
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, input bit push, input bit rnd_rdy);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 300) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", W'(in_ready), W'(1));
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        e        = model(a, b, sub, cin);
        e.acc    = cyc + 1;
        if (push) sb.push_back(e);
        tick();
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_sub   = 1'($urandom);
        in_cin   = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", W'(sb.size()), W'(0));
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        exp_t bp;
        int   n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;

        #2;
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_sum", out_sum, W'(0));
        chk("rst_out_cout", W'(out_cout), W'(0));
        chk("rst_out_ovf", W'(out_ovf), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        #10;
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", W'(in_ready), W'(1));

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h0, 64'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h5, 64'h3, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle();
        do_op(64'h2, 64'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Backpressure: result must hold and new operands must be refused.
        out_ready = 1'b0;
        bp = model(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b1);
        do_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_out_valid_rise", W'(out_valid), W'(1));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            tick();
            chk("bp_out_valid_hold", W'(out_valid), W'(1));
            chk("bp_out_sum_hold", out_sum, bp.sum);
            chk("bp_in_ready_low", W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", W'(in_ready), W'(1));
        chk("bp_out_valid_drop", W'(out_valid), W'(0));
        do_op(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Reset in the middle of RUN at word index 2.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_out_sum", out_sum, W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready_after", W'(in_ready), W'(1));
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            do_op(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
        end
        wait_idle();
        chk("scoreboard_empty", W'(sb.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
